// File: rtl/wb_commit_unit_if.sv
// MEM -> WB commit bundle handshake: MEM drives the master side, the commit unit is the slave.
interface wb_commit_unit_if #(
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned EXCP_W   = 16,
  parameter int unsigned RIDX_W   = 5
);
  logic                       in_valid;
  logic                       in_ready;
  logic [COMMIT_W-1:0]        in_slot_valid;
  logic [COMMIT_W*DATA_W-1:0] in_pc;
  logic [COMMIT_W-1:0]        in_wreg_en;
  logic [COMMIT_W*RIDX_W-1:0] in_wreg_idx;
  logic [COMMIT_W*DATA_W-1:0] in_wdata;
  logic [COMMIT_W*DATA_W-1:0] in_mem_addr;
  logic [COMMIT_W*EXCP_W-1:0] in_excp_num;
  logic [COMMIT_W-1:0]        in_ertn;

  modport master (
    output in_valid, in_slot_valid, in_pc, in_wreg_en, in_wreg_idx,
           in_wdata, in_mem_addr, in_excp_num, in_ertn,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_slot_valid, in_pc, in_wreg_en, in_wreg_idx,
           in_wdata, in_mem_addr, in_excp_num, in_ertn,
    output in_ready
  );
endinterface

// File: rtl/wb_commit_unit.sv
// N-wide in-order writeback/commit stage: retires slots older than the first trap and raises flushes.
// Optional WB_SOFT_INT_EN adds a soft_int input that forces an INT trap on slot 0.
module wb_commit_unit #(
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned EXCP_W   = 16,
  parameter int unsigned RIDX_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       icache_busy,
`ifdef WB_SOFT_INT_EN
  input  logic                       soft_int,
`endif
  wb_commit_unit_if.slave            mem,
  output logic [COMMIT_W-1:0]        rf_we,
  output logic [COMMIT_W*RIDX_W-1:0] rf_waddr,
  output logic [COMMIT_W*DATA_W-1:0] rf_wdata,
  output logic                       excp_flush,
  output logic                       ertn_flush,
  output logic [DATA_W-1:0]          excp_era,
  output logic [5:0]                 ecode,
  output logic [8:0]                 esubcode,
  output logic [DATA_W-1:0]          badv,
  output logic                       badv_valid,
  output logic [31:0]                retire_cnt
);
  localparam int unsigned CNT_W = $clog2(COMMIT_W + 1);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT_IC = 2'd1, FLUSH = 2'd2} state_e;
  typedef enum logic [1:0] {BADV_NONE = 2'd0, BADV_PC = 2'd1, BADV_ADDR = 2'd2} badv_src_e;

  state_e                     state;
  logic                       buf_valid;
  logic [COMMIT_W-1:0]        buf_slot_valid, buf_wreg_en, buf_ertn;
  logic [COMMIT_W*DATA_W-1:0] buf_pc, buf_wdata, buf_mem_addr;
  logic [COMMIT_W*RIDX_W-1:0] buf_wreg_idx;
  logic [COMMIT_W*EXCP_W-1:0] buf_excp_num;

  logic [COMMIT_W-1:0] live, below_t, we_raw;
  logic                has_trap, trap_excp, soft_hit, found, bit_found;
  logic [EXCP_W-1:0]   trap_vec;
  logic [DATA_W-1:0]   trap_pc, trap_addr;
  logic                commit, do_flush, in_ready_c, load;
  logic [CNT_W-1:0]    retire_inc;
  logic [5:0]          exc_code;
  logic [8:0]          exc_sub;
  badv_src_e           badv_src;

`ifdef WB_SOFT_INT_EN
  assign soft_hit = buf_valid & soft_int;
`else
  assign soft_hit = 1'b0;
`endif

  assign live = buf_slot_valid & {COMMIT_W{buf_valid}};

  // Oldest live slot carrying an exception or ERTN; below_t marks slots strictly older than it.
  always_comb begin
    found     = 1'b0;
    trap_vec  = '0;
    trap_pc   = '0;
    trap_addr = '0;
    below_t   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (!found && live[k] &&
          (buf_excp_num[k*EXCP_W +: EXCP_W] != '0 || buf_ertn[k])) begin
        found     = 1'b1;
        trap_vec  = buf_excp_num[k*EXCP_W +: EXCP_W];
        trap_pc   = buf_pc[k*DATA_W +: DATA_W];
        trap_addr = buf_mem_addr[k*DATA_W +: DATA_W];
      end
      below_t[k] = !found;
    end
    if (soft_hit) begin
      found     = 1'b1;
      trap_vec  = EXCP_W'(1);
      trap_pc   = buf_pc[DATA_W-1:0];
      trap_addr = '0;
      below_t   = '0;
    end
    has_trap = found;
  end

  assign trap_excp  = (trap_vec != '0);
  assign commit     = buf_valid & (!has_trap | !icache_busy);
  assign do_flush   = commit & has_trap;
  assign in_ready_c = reset & (state == RUN) & (!buf_valid | commit);
  assign load       = mem.in_valid & in_ready_c & !do_flush;
  assign mem.in_ready = in_ready_c;

  // Regfile writes; a younger retiring slot to the same register masks the older one.
  always_comb begin
    we_raw     = live & below_t & buf_wreg_en;
    rf_we      = '0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    retire_inc = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (buf_wreg_idx[k*RIDX_W +: RIDX_W] == '0) we_raw[k] = 1'b0;
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      rf_we[k] = commit & we_raw[k];
      for (int j = k + 1; j < COMMIT_W; j++) begin
        if (we_raw[j] && buf_wreg_idx[j*RIDX_W +: RIDX_W] == buf_wreg_idx[k*RIDX_W +: RIDX_W])
          rf_we[k] = 1'b0;
      end
      if (rf_we[k]) begin
        rf_waddr[k*RIDX_W +: RIDX_W] = buf_wreg_idx[k*RIDX_W +: RIDX_W];
        rf_wdata[k*DATA_W +: DATA_W] = buf_wdata[k*DATA_W +: DATA_W];
      end
      if (live[k] && below_t[k]) retire_inc = retire_inc + CNT_W'(1);
    end
  end

  // Lowest set excp_num bit selects ecode/esubcode and the badv source.
  always_comb begin
    exc_code  = '0;
    exc_sub   = '0;
    badv_src  = BADV_NONE;
    bit_found = 1'b0;
    for (int b = 0; b < EXCP_W; b++) begin
      if (!bit_found && trap_vec[b]) begin
        bit_found = 1'b1;
        case (b)
          0:       begin exc_code = 6'h00; badv_src = BADV_NONE; end
          1:       begin exc_code = 6'h08; badv_src = BADV_PC;   end
          2:       begin exc_code = 6'h3F; badv_src = BADV_PC;   end
          3:       begin exc_code = 6'h03; badv_src = BADV_PC;   end
          4:       begin exc_code = 6'h07; badv_src = BADV_PC;   end
          5:       begin exc_code = 6'h0B; badv_src = BADV_NONE; end
          6:       begin exc_code = 6'h0C; badv_src = BADV_NONE; end
          7:       begin exc_code = 6'h0D; badv_src = BADV_NONE; end
          8:       begin exc_code = 6'h0E; badv_src = BADV_NONE; end
          9:       begin exc_code = 6'h09; badv_src = BADV_ADDR; end
          10:      begin exc_code = 6'h08; exc_sub = 9'd1; badv_src = BADV_ADDR; end
          11:      begin exc_code = 6'h3F; badv_src = BADV_ADDR; end
          12:      begin exc_code = 6'h04; badv_src = BADV_ADDR; end
          13:      begin exc_code = 6'h07; badv_src = BADV_ADDR; end
          14:      begin exc_code = 6'h02; badv_src = BADV_ADDR; end
          15:      begin exc_code = 6'h01; badv_src = BADV_ADDR; end
          default: begin exc_code = 6'h00; badv_src = BADV_NONE; end
        endcase
      end
    end
  end

  assign excp_flush = do_flush & trap_excp;
  assign ertn_flush = do_flush & !trap_excp;
  assign excp_era   = excp_flush ? trap_pc : '0;
  assign ecode      = excp_flush ? exc_code : '0;
  assign esubcode   = excp_flush ? exc_sub : '0;
  assign badv_valid = excp_flush & (badv_src != BADV_NONE);
  assign badv       = !badv_valid ? '0 : ((badv_src == BADV_PC) ? trap_pc : trap_addr);

  // Bundle buffer, flush sequencing and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= RUN;
      buf_valid      <= 1'b0;
      buf_slot_valid <= '0;
      buf_wreg_en    <= '0;
      buf_ertn       <= '0;
      buf_pc         <= '0;
      buf_wdata      <= '0;
      buf_mem_addr   <= '0;
      buf_wreg_idx   <= '0;
      buf_excp_num   <= '0;
      retire_cnt     <= '0;
    end else begin
      if (commit) retire_cnt <= retire_cnt + 32'(retire_inc);
      case (state)
        RUN:     if (buf_valid && has_trap) state <= icache_busy ? WAIT_IC : FLUSH;
        WAIT_IC: if (commit) state <= has_trap ? FLUSH : RUN;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
      if (load) begin
        buf_valid      <= 1'b1;
        buf_slot_valid <= mem.in_slot_valid;
        buf_wreg_en    <= mem.in_wreg_en;
        buf_ertn       <= mem.in_ertn;
        buf_pc         <= mem.in_pc;
        buf_wdata      <= mem.in_wdata;
        buf_mem_addr   <= mem.in_mem_addr;
        buf_wreg_idx   <= mem.in_wreg_idx;
        buf_excp_num   <= mem.in_excp_num;
      end else if (commit) begin
        buf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed commit/trap scenarios plus randomized bundles.
module tb_wb_commit_unit;
  localparam int unsigned CW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = 16;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic icache_busy;
`ifdef WB_SOFT_INT_EN
  logic soft_int = 1'b0;
`endif
  logic [CW-1:0]    rf_we;
  logic [CW*RW-1:0] rf_waddr;
  logic [CW*DW-1:0] rf_wdata;
  logic             excp_flush, ertn_flush, badv_valid;
  logic [DW-1:0]    excp_era, badv;
  logic [5:0]       ecode;
  logic [8:0]       esubcode;
  logic [31:0]      retire_cnt;

  wb_commit_unit_if #(.COMMIT_W(CW), .DATA_W(DW), .EXCP_W(EW), .RIDX_W(RW)) mem_if ();

  wb_commit_unit #(.COMMIT_W(CW), .DATA_W(DW), .EXCP_W(EW), .RIDX_W(RW)) dut (
    .clk(clk), .reset(reset), .icache_busy(icache_busy),
`ifdef WB_SOFT_INT_EN
    .soft_int(soft_int),
`endif
    .mem(mem_if.slave),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .excp_era(excp_era),
    .ecode(ecode), .esubcode(esubcode), .badv(badv), .badv_valid(badv_valid),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_cnt;

  // Current bundle, one entry per slot
  logic          b_sv   [CW];
  logic [DW-1:0] b_pc   [CW];
  logic          b_wen  [CW];
  logic [RW-1:0] b_idx  [CW];
  logic [DW-1:0] b_wd   [CW];
  logic [DW-1:0] b_addr [CW];
  logic [EW-1:0] b_excp [CW];
  logic          b_ertn [CW];
  logic [5:0]    ecode_tbl [16];

  // Reference expectations for the commit cycle
  logic [CW-1:0] e_we;
  logic          e_xf, e_ef, e_bv, e_trap;
  logic [5:0]    e_code;
  logic [8:0]    e_sub;
  logic [DW-1:0] e_badv, e_era;
  int            e_ret;

  task automatic set_slot(input int k, input logic sv, input logic [DW-1:0] pc, input logic wen,
                          input logic [RW-1:0] idx, input logic [DW-1:0] wd,
                          input logic [DW-1:0] addr, input logic [EW-1:0] ex, input logic er);
    b_sv[k] = sv; b_pc[k] = pc; b_wen[k] = wen; b_idx[k] = idx;
    b_wd[k] = wd; b_addr[k] = addr; b_excp[k] = ex; b_ertn[k] = er;
  endtask

  // Presents the bundle for one edge; returns at the negedge of the commit cycle.
  task automatic load_bundle();
    @(negedge clk);
    for (int k = 0; k < CW; k++) begin
      mem_if.in_slot_valid[k]        = b_sv[k];
      mem_if.in_pc[k*DW +: DW]       = b_pc[k];
      mem_if.in_wreg_en[k]           = b_wen[k];
      mem_if.in_wreg_idx[k*RW +: RW] = b_idx[k];
      mem_if.in_wdata[k*DW +: DW]    = b_wd[k];
      mem_if.in_mem_addr[k*DW +: DW] = b_addr[k];
      mem_if.in_excp_num[k*EW +: EW] = b_excp[k];
      mem_if.in_ertn[k]              = b_ertn[k];
    end
    mem_if.in_valid = 1'b1;
    icache_busy = 1'b0;
    @(negedge clk);
    mem_if.in_valid = 1'b0;
  endtask

  // Program-order model: first trapping slot, older slots retire, last writer of a register wins.
  task automatic model_bundle();
    int t;
    int lb;
    logic hidden;
    t = CW;
    for (int k = CW - 1; k >= 0; k--)
      if (b_sv[k] && (b_excp[k] != 0 || b_ertn[k])) t = k;
    e_we = '0; e_ret = 0; e_xf = 0; e_ef = 0; e_bv = 0;
    e_code = '0; e_sub = '0; e_badv = '0; e_era = '0;
    e_trap = (t < CW);
    for (int k = 0; k < t; k++) begin
      if (b_sv[k]) begin
        e_ret++;
        if (b_wen[k] && b_idx[k] != 0) begin
          hidden = 1'b0;
          for (int j = k + 1; j < t; j++)
            if (b_sv[j] && b_wen[j] && b_idx[j] == b_idx[k]) hidden = 1'b1;
          e_we[k] = !hidden;
        end
      end
    end
    if (e_trap) begin
      if (b_excp[t] != 0) begin
        lb = -1;
        for (int b = EW - 1; b >= 0; b--) if (b_excp[t][b]) lb = b;
        e_xf = 1'b1;
        e_code = ecode_tbl[lb];
        e_sub = (lb == 10) ? 9'd1 : 9'd0;
        e_era = b_pc[t];
        if (lb >= 1 && lb <= 4) begin e_bv = 1'b1; e_badv = b_pc[t]; end
        else if (lb >= 9) begin e_bv = 1'b1; e_badv = b_addr[t]; end
      end else begin
        e_ef = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    mem_if.in_valid = 1'b1; mem_if.in_slot_valid = '1; mem_if.in_pc = '1;
    mem_if.in_wreg_en = '1; mem_if.in_wreg_idx = '1; mem_if.in_wdata = '1;
    mem_if.in_mem_addr = '1; mem_if.in_excp_num = '1; mem_if.in_ertn = '1;
    icache_busy = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem_if.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", mem_if.in_ready); end
    n_cmp++; if (rf_we !== '0) begin n_err++; $display("FAIL reset_rf_we: got %b want 00", rf_we); end
    n_cmp++; if ({excp_flush, ertn_flush, badv_valid} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {excp_flush, ertn_flush, badv_valid}); end
    n_cmp++; if ({ecode, esubcode, excp_era, badv} !== '0) begin n_err++; $display("FAIL reset_excp_bus: got %h want 0", {ecode, esubcode, excp_era, badv}); end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_err++; $display("FAIL reset_retire_cnt: got %0d want 0", retire_cnt); end
    mem_if.in_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    model_cnt = 0;
    #1;
    n_cmp++; if (mem_if.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", mem_if.in_ready); end
  endtask

  task automatic test_commit();
    set_slot(0, 1, 32'h1c000000, 1, 5'd4, 32'h11, 32'h0, 16'h0, 0);
    set_slot(1, 1, 32'h1c000004, 1, 5'd5, 32'h22, 32'h0, 16'h0, 0);
    load_bundle();
    #1;
    n_cmp++; if (rf_we !== 2'b11) begin n_err++; $display("FAIL commit_rf_we: got %b want 11", rf_we); end
    n_cmp++; if (rf_waddr !== {5'd5, 5'd4}) begin n_err++; $display("FAIL commit_waddr: got %h want %h", rf_waddr, {5'd5, 5'd4}); end
    n_cmp++; if (rf_wdata !== {32'h22, 32'h11}) begin n_err++; $display("FAIL commit_wdata: got %h want 0000002200000011", rf_wdata); end
    n_cmp++; if (excp_flush !== 1'b0) begin n_err++; $display("FAIL commit_no_flush: got %b want 0", excp_flush); end
    model_cnt += 2;
    @(negedge clk); #1;
    n_cmp++; if (retire_cnt !== model_cnt) begin n_err++; $display("FAIL commit_retire_cnt: got %0d want %0d", retire_cnt, model_cnt); end
  endtask

  task automatic test_ale();
    set_slot(0, 1, 32'h1c000000, 1, 5'd6, 32'h33, 32'h0, 16'h0, 0);
    set_slot(1, 1, 32'h1c000004, 1, 5'd8, 32'h44, 32'h1003, 16'h0200, 0);
    load_bundle();
    #1;
    n_cmp++; if (rf_we !== 2'b01) begin n_err++; $display("FAIL ale_rf_we: got %b want 01", rf_we); end
    n_cmp++; if (excp_flush !== 1'b1 || ertn_flush !== 1'b0) begin n_err++; $display("FAIL ale_flush: got %b%b want 10", excp_flush, ertn_flush); end
    n_cmp++; if (ecode !== 6'h09) begin n_err++; $display("FAIL ale_ecode: got %h want 09", ecode); end
    n_cmp++; if (badv !== 32'h1003 || badv_valid !== 1'b1) begin n_err++; $display("FAIL ale_badv: got %h/%b want 00001003/1", badv, badv_valid); end
    n_cmp++; if (excp_era !== 32'h1c000004) begin n_err++; $display("FAIL ale_era: got %h want 1c000004", excp_era); end
    model_cnt += 1;
    @(negedge clk); #1;
    n_cmp++; if (mem_if.in_ready !== 1'b0) begin n_err++; $display("FAIL ale_flush_in_ready: got %b want 0", mem_if.in_ready); end
    n_cmp++; if (retire_cnt !== model_cnt) begin n_err++; $display("FAIL ale_retire_cnt: got %0d want %0d", retire_cnt, model_cnt); end
  endtask

  task automatic test_ertn();
    set_slot(0, 1, 32'h1c000100, 0, 5'd0, 32'h0, 32'h0, 16'h0, 1);
    set_slot(1, 1, 32'h1c000104, 1, 5'd9, 32'h55, 32'h0, 16'h0, 0);
    load_bundle();
    #1;
    n_cmp++; if (ertn_flush !== 1'b1 || excp_flush !== 1'b0) begin n_err++; $display("FAIL ertn_flush: got %b%b want 01", excp_flush, ertn_flush); end
    n_cmp++; if (rf_we !== 2'b00) begin n_err++; $display("FAIL ertn_rf_we: got %b want 00", rf_we); end
    n_cmp++; if ({ecode, esubcode, badv_valid} !== '0) begin n_err++; $display("FAIL ertn_excp_zero: got %h want 0", {ecode, esubcode, badv_valid}); end
    @(negedge clk); #1;
    n_cmp++; if (retire_cnt !== model_cnt) begin n_err++; $display("FAIL ertn_retire_cnt: got %0d want %0d", retire_cnt, model_cnt); end
  endtask

  task automatic test_icache_wait();
    set_slot(0, 1, 32'h1c000200, 0, 5'd0, 32'h0, 32'h0, 16'h0020, 0);
    set_slot(1, 1, 32'h1c000204, 1, 5'd3, 32'h66, 32'h0, 16'h0, 0);
    load_bundle();
    for (int i = 0; i < 3; i++) begin
      icache_busy = 1'b1;
      #1;
      n_cmp++; if (excp_flush !== 1'b0 || rf_we !== 2'b00) begin n_err++; $display("FAIL icwait_hold_%0d: flush %b rf_we %b want 0 00", i, excp_flush, rf_we); end
      n_cmp++; if (mem_if.in_ready !== 1'b0) begin n_err++; $display("FAIL icwait_in_ready_%0d: got %b want 0", i, mem_if.in_ready); end
      @(negedge clk);
    end
    icache_busy = 1'b0;
    #1;
    n_cmp++; if (excp_flush !== 1'b1 || ecode !== 6'h0B) begin n_err++; $display("FAIL icwait_flush: got %b/%h want 1/0b", excp_flush, ecode); end
    n_cmp++; if (badv_valid !== 1'b0 || excp_era !== 32'h1c000200) begin n_err++; $display("FAIL icwait_era: got %b/%h want 0/1c000200", badv_valid, excp_era); end
    @(negedge clk); #1;
    n_cmp++; if (mem_if.in_ready !== 1'b0) begin n_err++; $display("FAIL icwait_post_in_ready: got %b want 0", mem_if.in_ready); end
  endtask

  task automatic test_waw();
    set_slot(0, 1, 32'h1c000300, 1, 5'd7, 32'hA, 32'h0, 16'h0, 0);
    set_slot(1, 1, 32'h1c000304, 1, 5'd7, 32'hB, 32'h0, 16'h0, 0);
    load_bundle();
    #1;
    n_cmp++; if (rf_we !== 2'b10) begin n_err++; $display("FAIL waw_rf_we: got %b want 10", rf_we); end
    n_cmp++; if (rf_waddr[9:5] !== 5'd7 || rf_wdata[63:32] !== 32'hB) begin n_err++; $display("FAIL waw_data: got r%0d=%h want r7=0000000b", rf_waddr[9:5], rf_wdata[63:32]); end
    model_cnt += 2;
    set_slot(0, 1, 32'h1c000308, 1, 5'd0, 32'hC, 32'h0, 16'h0, 0);
    set_slot(1, 1, 32'h1c00030c, 1, 5'd0, 32'hD, 32'h0, 16'h0, 0);
    load_bundle();
    #1;
    n_cmp++; if (rf_we !== 2'b00) begin n_err++; $display("FAIL r0_rf_we: got %b want 00", rf_we); end
    model_cnt += 2;
    @(negedge clk); #1;
    n_cmp++; if (retire_cnt !== model_cnt) begin n_err++; $display("FAIL waw_retire_cnt: got %0d want %0d", retire_cnt, model_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    set_slot(0, 1, 32'h1c000400, 1, 5'd2, 32'h77, 32'h0, 16'h0, 0);
    set_slot(1, 1, 32'h1c000404, 0, 5'd0, 32'h0, 32'h0, 16'h0020, 0);
    load_bundle();
    icache_busy = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (mem_if.in_ready !== 1'b0 || rf_we !== '0) begin n_err++; $display("FAIL midwait_reset_ready_we: got %b/%b want 0/00", mem_if.in_ready, rf_we); end
    n_cmp++; if ({excp_flush, ertn_flush, badv_valid, ecode, excp_era} !== '0) begin n_err++; $display("FAIL midwait_reset_excp: got %h want 0", {excp_flush, ertn_flush, badv_valid, ecode, excp_era}); end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_err++; $display("FAIL midwait_reset_cnt: got %0d want 0", retire_cnt); end
    @(negedge clk) reset = 1'b1;
    model_cnt = 0;
    #1;
    n_cmp++; if (mem_if.in_ready !== 1'b1 || excp_flush !== 1'b0) begin n_err++; $display("FAIL midwait_release: ready %b flush %b want 1 0", mem_if.in_ready, excp_flush); end
    icache_busy = 1'b0;
  endtask

  task automatic test_random();
    int r;
    int busy;
    for (int it = 0; it < 80; it++) begin
      for (int k = 0; k < CW; k++) begin
        r = $urandom_range(0, 9);
        set_slot(k, ($urandom_range(0, 7) != 0), 32'h1c000000 + 32'($urandom_range(0, 4095)) * 4,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, $urandom,
                 (r < 6) ? 16'h0 : ((r < 9) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom)),
                 ($urandom_range(0, 7) == 0));
      end
      model_bundle();
      busy = e_trap ? $urandom_range(0, 2) : 0;
      load_bundle();
      for (int i = 0; i < busy; i++) begin
        icache_busy = 1'b1;
        #1;
        n_cmp++; if ({rf_we, excp_flush, ertn_flush, mem_if.in_ready} !== '0) begin n_err++; $display("FAIL rand_hold it%0d: we/xf/ef/rdy %b want 0", it, {rf_we, excp_flush, ertn_flush, mem_if.in_ready}); end
        @(negedge clk);
      end
      icache_busy = e_trap ? 1'b0 : 1'($urandom_range(0, 1));
      mem_if.in_valid = e_trap ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      n_cmp++; if (rf_we !== e_we) begin n_err++; $display("FAIL rand_rf_we it%0d: got %b want %b", it, rf_we, e_we); end
      for (int k = 0; k < CW; k++) begin
        if (e_we[k]) begin
          n_cmp++;
          if (rf_waddr[k*RW +: RW] !== b_idx[k] || rf_wdata[k*DW +: DW] !== b_wd[k]) begin
            n_err++; $display("FAIL rand_wr it%0d slot%0d: got r%0d=%h want r%0d=%h", it, k, rf_waddr[k*RW +: RW], rf_wdata[k*DW +: DW], b_idx[k], b_wd[k]);
          end
        end
      end
      n_cmp++; if ({excp_flush, ertn_flush} !== {e_xf, e_ef}) begin n_err++; $display("FAIL rand_flush it%0d: got %b%b want %b%b", it, excp_flush, ertn_flush, e_xf, e_ef); end
      if (e_trap) begin
        n_cmp++; if ({ecode, esubcode} !== {e_code, e_sub}) begin n_err++; $display("FAIL rand_ecode it%0d: got %h/%h want %h/%h", it, ecode, esubcode, e_code, e_sub); end
        n_cmp++; if ({badv_valid, badv, excp_era} !== {e_bv, e_badv, e_era}) begin n_err++; $display("FAIL rand_badv it%0d: got %b/%h/%h want %b/%h/%h", it, badv_valid, badv, excp_era, e_bv, e_badv, e_era); end
      end else begin
        n_cmp++; if (mem_if.in_ready !== 1'b1) begin n_err++; $display("FAIL rand_ready it%0d: got %b want 1", it, mem_if.in_ready); end
      end
      model_cnt += 32'(e_ret);
      @(negedge clk);
      mem_if.in_valid = e_trap ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      n_cmp++; if (retire_cnt !== model_cnt) begin n_err++; $display("FAIL rand_cnt it%0d: got %0d want %0d", it, retire_cnt, model_cnt); end
      if (e_trap) begin
        n_cmp++; if (mem_if.in_ready !== 1'b0 || rf_we !== '0) begin n_err++; $display("FAIL rand_flushcyc it%0d: ready %b we %b want 0 00", it, mem_if.in_ready, rf_we); end
        @(negedge clk);
        mem_if.in_valid = 1'b0;
        #1;
        n_cmp++; if (mem_if.in_ready !== 1'b1 || {rf_we, excp_flush, ertn_flush} !== '0) begin n_err++; $display("FAIL rand_dropped it%0d: ready %b we/xf/ef %b want 1 0", it, mem_if.in_ready, {rf_we, excp_flush, ertn_flush}); end
      end
      icache_busy = 1'b0;
    end
  endtask

  initial begin
    ecode_tbl = '{6'h00, 6'h08, 6'h3F, 6'h03, 6'h07, 6'h0B, 6'h0C, 6'h0D,
                  6'h0E, 6'h09, 6'h08, 6'h3F, 6'h04, 6'h07, 6'h02, 6'h01};
    model_cnt = 0;
    test_reset();
    test_commit();
    test_ale();
    test_ertn();
    test_icache_wait();
    test_waw();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
